morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Receive side of the Morse link: samples a keyed on/off line (key or tone-detector output) and turns it back into ASCII characters.
- Measures mark and space durations in dot units and classifies each mark as a dot or a dash.
- Emits one character per letter gap, and a space (0x20) per word gap.
- Sits after the keying input; its output feeds a UART or LCD writer through a one-cycle valid pulse.

Parameters:
- UNIT_CYCLES, 2500000, iCLK cycles per Morse dot unit (50 ms at 50 MHz); must be >= 4.
- DEB_CYCLES, 250000, cycles the synchronized key must stay stable before a level change is accepted; must be >= 1.
- DASH_UNITS, 2, mark length in units at or above which a mark is a dash.
- CHAR_UNITS, 3, space length in units that ends a character.
- WORD_UNITS, 7, space length in units that ends a word.

Ports:
- iCLK  in  1  system clock; every register is clocked on the rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iKEY  in  1  raw keyed line, 1 = tone/mark; asynchronous to iCLK.
- oCHAR  out  8  ASCII of the last decoded symbol; holds its value until the next oVALID.
- oVALID  out  1  one-cycle pulse; oCHAR is valid in that cycle.
- oERR  out  1  one-cycle pulse coincident with oVALID when the pattern is unknown or too long.
- oBUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; oCHAR=8'h00; oVALID=0; oERR=0; oBUSY=0; all counters, symbol and length registers are zero.
- Input path: iKEY passes a 2-flop synchronizer. A debounced level then changes only after DEB_CYCLES consecutive cycles of a differing synchronized value. Every rise or fall below refers to the debounced level.
- Timing: the prescaler counts 0..UNIT_CYCLES-1 and produces a unit tick on wrap. The unit counter (3 bits) increments on each tick and saturates at 7. Both counters clear on every debounced edge.
- Symbol store: sym[4:0] is a shift register, filled LSB-first in arrival order, with 0 = dot and 1 = dash. len[2:0] counts symbols stored. ovf is a sticky flag set when a sixth symbol arrives.
- States:
  - IDLE: a rise goes to MARK.
  - MARK: on a fall, record a dash if units >= DASH_UNITS, otherwise a dot (this includes zero-unit marks). If len==5, set ovf and do not shift. Go to SPACE.
  - SPACE, rise before units==CHAR_UNITS: go to MARK. The symbol continues the same character.
  - SPACE, units reaches CHAR_UNITS and len>0: in that same cycle pulse oVALID and drive oCHAR from the lookup. If there is no match or ovf is set, oCHAR=8'h3F and oERR pulses. Then clear sym, len and ovf, and stay in SPACE.
  - SPACE, units reaches WORD_UNITS: pulse oVALID with oCHAR=8'h20, then go to IDLE. A rise after the character was emitted but before this point goes to MARK with no space emitted.
- Lookup: covers A–Z and 0–9 in international Morse, upper-case ASCII. {len, sym} patterns outside that set count as unknown.
- Emission rules:
  - Emission happens only on the tick where units first equals the threshold. Saturation therefore never re-emits.
  - oVALID is never high on two consecutive cycles.
- Latency: a character is emitted CHAR_UNITS*UNIT_CYCLES cycles after the debounced fall of its last mark. The debounced fall itself lags iKEY by 2+DEB_CYCLES cycles.
- Reset mid-character: the partial symbol is discarded and nothing is emitted.

Decomposition:
- Shared package morse_pkg: the Morse code table (len/pattern per character), ASCII constants for space (0x20) and error (0x3F), a state enum of IDLE/MARK/SPACE, and the max symbol length of 5.
- The same table is reused by the encoder.
- One natural sub-module: morse_lut, a combinational mapping of {len[2:0], sym[4:0]} to {hit, ascii[7:0]}.

Test Plan:
All scenarios use UNIT_CYCLES=8 and DEB_CYCLES=2; "mark N / space N" means N units of iKEY high / low.
- "A": mark1 space1 mark3 space3 -> one oVALID, oCHAR=0x41, oERR=0; then space continues to 7 units -> oVALID, oCHAR=0x20, oBUSY drops.
- "SOS" with letter gaps of 3 units -> oCHAR sequence 0x53, 0x4F, 0x53, then 0x20 after a final 7-unit space.
- "5" (five dots) -> 0x35. Six dots -> oCHAR=0x3F with oERR=1 in the same cycle as oVALID.
- Unknown pattern dash-dash-dot-dot-dash (pattern not in the table) -> 0x3F with oERR pulse.
- iKEY glitch of 1 cycle high during a space -> no state change, no output.
- iRST_N low for 3 cycles in the middle of a dash-dot -> all outputs 0, state IDLE. A following "E" (mark1, space 7) yields 0x45 then 0x20 only.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, ASCII constants and the A-Z/0-9 code table.
// Patterns are stored first-symbol-in-bit-0, with 0 = dot and 1 = dash.
package morse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2
   } state_t;

   localparam int         MAX_SYM_LEN = 5;
   localparam int         NUM_CODES   = 36;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ERR   = 8'h3F;

   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pat;
      logic [7:0] ascii;
   } morse_code_t;

   localparam morse_code_t MORSE_TABLE [NUM_CODES] = '{
      {3'd2, 5'b00010, 8'h41}, {3'd4, 5'b00001, 8'h42}, {3'd4, 5'b00101, 8'h43},
      {3'd3, 5'b00001, 8'h44}, {3'd1, 5'b00000, 8'h45}, {3'd4, 5'b00100, 8'h46},
      {3'd3, 5'b00011, 8'h47}, {3'd4, 5'b00000, 8'h48}, {3'd2, 5'b00000, 8'h49},
      {3'd4, 5'b01110, 8'h4A}, {3'd3, 5'b00101, 8'h4B}, {3'd4, 5'b00010, 8'h4C},
      {3'd2, 5'b00011, 8'h4D}, {3'd2, 5'b00001, 8'h4E}, {3'd3, 5'b00111, 8'h4F},
      {3'd4, 5'b00110, 8'h50}, {3'd4, 5'b01011, 8'h51}, {3'd3, 5'b00010, 8'h52},
      {3'd3, 5'b00000, 8'h53}, {3'd1, 5'b00001, 8'h54}, {3'd3, 5'b00100, 8'h55},
      {3'd4, 5'b01000, 8'h56}, {3'd3, 5'b00110, 8'h57}, {3'd4, 5'b01001, 8'h58},
      {3'd4, 5'b01101, 8'h59}, {3'd4, 5'b00011, 8'h5A},
      {3'd5, 5'b11111, 8'h30}, {3'd5, 5'b11110, 8'h31}, {3'd5, 5'b11100, 8'h32},
      {3'd5, 5'b11000, 8'h33}, {3'd5, 5'b10000, 8'h34}, {3'd5, 5'b00000, 8'h35},
      {3'd5, 5'b00001, 8'h36}, {3'd5, 5'b00011, 8'h37}, {3'd5, 5'b00111, 8'h38},
      {3'd5, 5'b01111, 8'h39}
   };

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse lookup: {len, sym} -> {hit, ascii}. Misses return the error character.
module morse_lut
   import morse_pkg::*;
(
   input  logic [2:0] len_i,
   input  logic [4:0] sym_i,
   output logic       hit_o,
   output logic [7:0] ascii_o
);

   always_comb begin
      hit_o   = 1'b0;
      ascii_o = ASCII_ERR;
      for (int i = 0; i < NUM_CODES; i++) begin
         if (MORSE_TABLE[i].len == len_i && MORSE_TABLE[i].pat == sym_i) begin
            hit_o   = 1'b1;
            ascii_o = MORSE_TABLE[i].ascii;
         end
      end
   end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: synchronizes and debounces the keyed line, times marks/spaces in dot
// units and emits one ASCII character per letter gap plus a space per word gap.
module morse_decoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 2500000,
   parameter int DEB_CYCLES  = 250000,
   parameter int DASH_UNITS  = 2,
   parameter int CHAR_UNITS  = 3,
   parameter int WORD_UNITS  = 7
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iKEY,
   output logic [7:0] oCHAR,
   output logic       oVALID,
   output logic       oERR,
   output logic       oBUSY
);

   localparam int PW = $clog2(UNIT_CYCLES);
   localparam int DW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    sync_q;
   logic          deb_q;
   logic [DW-1:0] deb_cnt_q;
   logic [PW-1:0] presc_q;
   logic [2:0]    units_q;

   logic          deb_flip, rise, fall, key_edge, tick, char_hit, word_hit;
   logic [2:0]    units_eff;

   assign deb_flip  = (sync_q[1] != deb_q) && (deb_cnt_q == DW'(DEB_CYCLES - 1));
   assign rise      = deb_flip &  sync_q[1];
   assign fall      = deb_flip & ~sync_q[1];
   assign key_edge  = deb_flip;
   assign tick      = (presc_q == PW'(UNIT_CYCLES - 1));
   // Unit count including a tick landing in this very cycle, so an edge exactly on a
   // unit boundary is measured as the full number of units.
   assign units_eff = (tick && units_q != 3'd7) ? units_q + 3'd1 : units_q;
   assign char_hit  = tick && (units_q == 3'(CHAR_UNITS - 1));
   assign word_hit  = tick && (units_q == 3'(WORD_UNITS - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sync_q    <= '0;
         deb_q     <= 1'b0;
         deb_cnt_q <= '0;
         presc_q   <= '0;
         units_q   <= '0;
      end else begin
         sync_q <= {sync_q[0], iKEY};
         if (sync_q[1] == deb_q || deb_flip) begin
            deb_cnt_q <= '0;
         end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
         end
         if (deb_flip) begin
            deb_q <= sync_q[1];
         end
         if (key_edge) begin
            presc_q <= '0;
            units_q <= '0;
         end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            units_q <= units_eff;
         end
      end
   end

   state_t     state_q, state_d;
   logic [4:0] sym_q, sym_d;
   logic [2:0] len_q, len_d;
   logic       ovf_q, ovf_d;
   logic [7:0] char_q, char_d;
   logic       valid_q, valid_d;
   logic       err_q, err_d;
   logic       lut_hit;
   logic [7:0] lut_ascii;

   morse_lut u_lut (
      .len_i   (len_q),
      .sym_i   (sym_q),
      .hit_o   (lut_hit),
      .ascii_o (lut_ascii)
   );

   // NOTE: every signal driven here gets a default first; a path that leaves one
   // unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      sym_d   = sym_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      char_d  = char_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) state_d = ST_MARK;
         end
         ST_MARK: begin
            if (fall) begin
               if (len_q == 3'(MAX_SYM_LEN)) begin
                  ovf_d = 1'b1;
               end else begin
                  sym_d = sym_q | (5'(units_eff >= 3'(DASH_UNITS)) << len_q);
                  len_d = len_q + 3'd1;
               end
               state_d = ST_SPACE;
            end
         end
         ST_SPACE: begin
            if (word_hit) begin
               valid_d = 1'b1;
               char_d  = ASCII_SPACE;
               state_d = ST_IDLE;
            end else if (char_hit && len_q != 3'd0) begin
               valid_d = 1'b1;
               err_d   = ~lut_hit | ovf_q;
               char_d  = err_d ? ASCII_ERR : lut_ascii;
               sym_d   = '0;
               len_d   = '0;
               ovf_d   = 1'b0;
            end
            // A rise coinciding with a gap threshold still emits, then starts a new mark.
            if (rise) state_d = ST_MARK;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= ST_IDLE;
         sym_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
         char_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sym_q   <= sym_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
         char_q  <= char_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign oCHAR  = char_q;
   assign oVALID = valid_q;
   assign oERR   = err_q;
   assign oBUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: directed and random keying sequences compared
// against a duration-based reference decoder using dot/dash strings.
module tb_morse_decoder;

   localparam int UNIT = 8;
   localparam int DEB  = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       key   = 1'b0;
   logic [7:0] ochar;
   logic       ovalid, oerr, obusy;

   always #5 clk = ~clk;

   morse_decoder #(
      .UNIT_CYCLES (UNIT),
      .DEB_CYCLES  (DEB),
      .DASH_UNITS  (2),
      .CHAR_UNITS  (3),
      .WORD_UNITS  (7)
   ) dut (
      .iCLK   (clk),
      .iRST_N (rst_n),
      .iKEY   (key),
      .oCHAR  (ochar),
      .oVALID (ovalid),
      .oERR   (oerr),
      .oBUSY  (obusy)
   );

   // kind: 0 = space (key low), 1 = mark (key high), 2 = one-cycle glitch high
   typedef struct {
      int kind;
      int cyc;
   } seg_t;

   seg_t       segs[$];
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic       prev_valid = 1'b0;

   string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                        "--...", "---..", "----."};
   string alphabet = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && ovalid) begin
         check("valid_back_to_back", 32'(prev_valid), 32'(0));
         obs_q.push_back({oerr, ochar});
      end
      if (rst_n && oerr) check("err_without_valid", 32'(ovalid), 32'(1));
      prev_valid <= ovalid;
   end

   function automatic logic [8:0] lookup(input string p);
      if (p.len() > 5) return {1'b1, 8'h3F};
      for (int i = 0; i < 36; i++) begin
         if (codes[i] == p) return {1'b0, 8'(alphabet[i])};
      end
      return {1'b1, 8'h3F};
   endfunction

   // Reference decoder: marks of >=2 units are dashes; a quiet stretch of >=3 units ends a
   // character, >=7 units ends a word (once per word).
   task automatic build_expected();
      string pat = "";
      bit    active = 1'b0;
      int    pend = 0;
      exp_q.delete();
      for (int i = 0; i <= segs.size(); i++) begin
         if (i == segs.size() || segs[i].kind == 1) begin
            if (pat.len() > 0 && pend >= 3 * UNIT) begin
               exp_q.push_back(lookup(pat));
               pat = "";
            end
            if (active && pend >= 7 * UNIT) begin
               exp_q.push_back({1'b0, 8'h20});
               active = 1'b0;
            end
            pend = 0;
            if (i < segs.size()) begin
               active = 1'b1;
               if (segs[i].cyc >= 2 * UNIT) pat = {pat, "-"};
               else pat = {pat, "."};
            end
         end else begin
            pend += segs[i].cyc;
         end
      end
   endtask

   task automatic add_char(input string code, input int gap, input bit rnd);
      for (int i = 0; i < code.len(); i++) begin
         seg_t s;
         s.kind = 1;
         if (code[i] == "-") s.cyc = rnd ? int'($urandom_range(18, 30)) : 3 * UNIT;
         else                s.cyc = rnd ? int'($urandom_range(4, 14))  : UNIT;
         segs.push_back(s);
         if (i != code.len() - 1) begin
            s.kind = 0;
            s.cyc  = rnd ? int'($urandom_range(6, 18)) : UNIT;
            segs.push_back(s);
         end
      end
      segs.push_back('{kind: 0, cyc: gap});
   endtask

   task automatic run_scenario(input string name);
      segs.push_back('{kind: 0, cyc: 80});
      build_expected();
      obs_q.delete();
      foreach (segs[i]) begin
         key = (segs[i].kind != 0);
         repeat (segs[i].kind == 2 ? 1 : segs[i].cyc) @(negedge clk);
         if (segs[i].kind == 1) check({name, "_busy_mark"}, 32'(obusy), 32'(1));
      end
      key = 1'b0;
      check({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) check({name, "_char"}, 32'(obs_q[i]), 32'(exp_q[i]));
      end
      check({name, "_busy_end"}, 32'(obusy), 32'(0));
      if (exp_q.size() > 0) check({name, "_hold"}, 32'(ochar), 32'(exp_q[$][7:0]));
      segs.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_char", 32'(ochar), 32'(0));
      check("rst_valid", 32'(ovalid), 32'(0));
      check("rst_err", 32'(oerr), 32'(0));
      check("rst_busy", 32'(obusy), 32'(0));
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      add_char(".-", 0, 1'b0);
      run_scenario("A");

      add_char("...", 3 * UNIT, 1'b0);
      add_char("---", 3 * UNIT, 1'b0);
      add_char("...", 0, 1'b0);
      run_scenario("SOS");

      add_char(".....", 0, 1'b0);
      run_scenario("five");

      add_char("......", 0, 1'b0);
      run_scenario("six_dots");

      add_char("--..-", 0, 1'b0);
      run_scenario("unknown");

      add_char(".", 30, 1'b0);
      segs.push_back('{kind: 2, cyc: 1});
      segs.push_back('{kind: 0, cyc: 40});
      run_scenario("glitch");

      // Reset in the middle of a dash-dot: nothing may come out.
      obs_q.delete();
      key = 1'b1; repeat (3 * UNIT) @(negedge clk);
      key = 1'b0; repeat (UNIT) @(negedge clk);
      key = 1'b1; repeat (4) @(negedge clk);
      rst_n = 1'b0;
      key   = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_char", 32'(ochar), 32'(0));
      check("midrst_valid", 32'(ovalid), 32'(0));
      check("midrst_err", 32'(oerr), 32'(0));
      check("midrst_busy", 32'(obusy), 32'(0));
      rst_n = 1'b1;
      repeat (10 * UNIT) @(negedge clk);
      check("midrst_no_output", 32'(obs_q.size()), 32'(0));
      add_char(".", 0, 1'b0);
      run_scenario("E_after_reset");

      for (int sc = 0; sc < 12; sc++) begin
         int nwords = int'($urandom_range(1, 2));
         for (int w = 0; w < nwords; w++) begin
            int nchars = int'($urandom_range(1, 3));
            for (int c = 0; c < nchars; c++) begin
               string code = "";
               int    len  = int'($urandom_range(1, 6));
               int    gap;
               for (int k = 0; k < len; k++) begin
                  if ($urandom_range(0, 1) == 1) code = {code, "-"};
                  else                           code = {code, "."};
               end
               if (c != nchars - 1)      gap = int'($urandom_range(26, 45));
               else if (w != nwords - 1) gap = int'($urandom_range(58, 70));
               else                      gap = 0;
               add_char(code, gap, 1'b1);
            end
         end
         run_scenario($sformatf("rand%0d", sc));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
